// File: rtl/qspi_rd_master.sv
// Single-bit SPI flash-read initiator: issues 03h/0Bh with a 24-bit address and
// returns one 32-bit word. Every output is a flop or a constant, so nothing glitches.
`timescale 1ns/1ps
module qspi_rd_master #(
  parameter int CLK_DIV = 4,
  parameter int CSN_GAP = 8
) (
  input  logic        fast_clk,
  input  logic        rst_n,
  input  logic        rd_req,
  input  logic        rd_cmd_fast,
  input  logic [23:0] rd_addr,
  output logic        rd_busy,
  output logic        rd_done,
  output logic [31:0] rd_data,
  output logic        qspi_clk,
  output logic        qspi_csn,
  output logic        qspi_di,
  input  logic        qspi_do,
  output logic        qspi_wpn,
  output logic        qspi_holdn
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LAST = 8'(CSN_GAP - 1);

  logic [2:0]  state;
  logic [7:0]  cnt;
  logic [6:0]  bit_cnt;
  logic [39:0] sr;
  logic [31:0] cap;
  logic        fast;
  logic        last_bit;
  logic        data_phase;

  assign last_bit   = (bit_cnt == (fast ? 7'd71 : 7'd63));
  assign data_phase = (bit_cnt >= (fast ? 7'd40 : 7'd32));

  // Opcode/address/dummy leave from the top of sr; zeros fill in behind them,
  // so the dummy and data phases drive 0 without extra muxing.
  assign qspi_di    = sr[39];
  assign qspi_wpn   = 1'b1;
  assign qspi_holdn = 1'b1;

  always_ff @(posedge fast_clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      bit_cnt  <= '0;
      sr       <= '0;
      cap      <= '0;
      fast     <= 1'b0;
      qspi_clk <= 1'b0;
      qspi_csn <= 1'b1;
      rd_busy  <= 1'b0;
      rd_done  <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (rd_req) begin
            sr       <= {(rd_cmd_fast ? 8'h0B : 8'h03), rd_addr, 8'h00};
            fast     <= rd_cmd_fast;
            cnt      <= '0;
            qspi_csn <= 1'b0;
            rd_busy  <= 1'b1;
            state    <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (cnt == DIV_LAST) begin
            cnt     <= '0;
            bit_cnt <= '0;
            state   <= S_SHIFT;
          end else cnt <= cnt + 8'd1;
        end
        S_SHIFT: begin
          if (cnt == DIV_LAST) begin
            cnt      <= '0;
            qspi_clk <= ~qspi_clk;
            // Falling edge: launch next MOSI bit, capture MISO at end of high phase.
            if (qspi_clk) begin
              sr <= {sr[38:0], 1'b0};
              if (data_phase) cap <= {cap[30:0], qspi_do};
              if (last_bit) state <= S_HOLD;
              else bit_cnt <= bit_cnt + 7'd1;
            end
          end else cnt <= cnt + 8'd1;
        end
        S_HOLD: begin
          if (cnt == DIV_LAST) begin
            cnt      <= '0;
            qspi_csn <= 1'b1;
            rd_done  <= 1'b1;
            rd_data  <= cap;
            state    <= S_GAP;
          end else cnt <= cnt + 8'd1;
        end
        S_GAP: begin
          if (cnt == GAP_LAST) begin
            cnt     <= '0;
            bit_cnt <= '0;
            rd_busy <= 1'b0;
            state   <= S_IDLE;
          end else cnt <= cnt + 8'd1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qspi_rd_master.sv
// Directed bench for qspi_rd_master: a D=4 instance and a D=5 instance, each
// with its own behavioural flash slave.
`timescale 1ns/1ps
module tb_qspi_rd_master;

  logic        fast_clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req, cmd;
  logic [23:0] addr0, addr1;
  wire  [1:0]  busy, done, qclk, csn, di, wpn, holdn;
  wire  [31:0] data0, data1;
  logic        so0 = 1'b0, so1 = 1'b0;

  int n_chk = 0, n_fail = 0;

  always #5 fast_clk = ~fast_clk;

  qspi_rd_master #(.CLK_DIV(4), .CSN_GAP(8)) dut (
    .fast_clk(fast_clk), .rst_n(rst_n), .rd_req(req[0]), .rd_cmd_fast(cmd[0]),
    .rd_addr(addr0), .rd_busy(busy[0]), .rd_done(done[0]), .rd_data(data0),
    .qspi_clk(qclk[0]), .qspi_csn(csn[0]), .qspi_di(di[0]), .qspi_do(so0),
    .qspi_wpn(wpn[0]), .qspi_holdn(holdn[0]));

  qspi_rd_master #(.CLK_DIV(5), .CSN_GAP(8)) dut5 (
    .fast_clk(fast_clk), .rst_n(rst_n), .rd_req(req[1]), .rd_cmd_fast(cmd[1]),
    .rd_addr(addr1), .rd_busy(busy[1]), .rd_done(done[1]), .rd_data(data1),
    .qspi_clk(qclk[1]), .qspi_csn(csn[1]), .qspi_di(di[1]), .qspi_do(so1),
    .qspi_wpn(wpn[1]), .qspi_holdn(holdn[1]));

  // Slave models: record MOSI on rising edges, drive MISO right after the rising edge
  // of each data bit. csn falling (clock low) restarts the bit count.
  int          rise0 = 0, rise1 = 0;
  logic [71:0] mosi0 = '0, mosi1 = '0;
  logic [7:0]  op0 = '0, op1 = '0;
  logic [31:0] word0 = '0, word1 = '0;

  always @(posedge qclk[0] or negedge csn[0]) begin
    if (!qclk[0]) begin
      rise0 = 0; mosi0 = '0;
    end else begin
      mosi0 = {mosi0[70:0], di[0]};
      if (rise0 == 7) op0 = mosi0[7:0];
      if (rise0 >= ((op0 == 8'h0B) ? 40 : 32))
        so0 = word0[31 - (rise0 - ((op0 == 8'h0B) ? 40 : 32))];
      rise0++;
    end
  end

  always @(posedge qclk[1] or negedge csn[1]) begin
    if (!qclk[1]) begin
      rise1 = 0; mosi1 = '0;
    end else begin
      mosi1 = {mosi1[70:0], di[1]};
      if (rise1 == 7) op1 = mosi1[7:0];
      if (rise1 >= ((op1 == 8'h0B) ? 40 : 32))
        so1 = word1[31 - (rise1 - ((op1 == 8'h0B) ? 40 : 32))];
      rise1++;
    end
  end

  int done_cnt0 = 0;
  int wp_bad = 0;
  always @(negedge fast_clk) begin
    if (done[0] === 1'b1) done_cnt0++;
    if (wpn !== 2'b11 || holdn !== 2'b11) wp_bad++;
  end

  // Phase-width monitor on the D=5 instance: high phases, and low phases between highs.
  logic prev5 = 1'b0;
  int   run5 = 0, bad5 = 0, nphase5 = 0;
  bit   seen_hi5 = 1'b0;
  always @(negedge fast_clk) begin
    if (qclk[1] !== prev5) begin
      if (prev5 === 1'b1) begin
        nphase5++; if (run5 != 5) bad5++; seen_hi5 = 1'b1;
      end else if (seen_hi5) begin
        nphase5++; if (run5 != 5) bad5++;
      end
      run5 = 1;
    end else run5++;
    prev5 = qclk[1];
    if (csn[1]) seen_hi5 = 1'b0;
  end

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_req(input int s, input bit f, input logic [23:0] a, input logic [31:0] w);
    int k;
    k = 0;
    while (busy[s] && k < 1000) begin @(negedge fast_clk); k++; end
    chk({tag_s(s), "_idle_before_req"}, busy[s], 0);
    if (s == 0) begin addr0 = a; word0 = w; end
    else begin addr1 = a; word1 = w; end
    cmd[s] = f;
    req[s] = 1'b1;
    @(negedge fast_clk);
    req[s] = 1'b0;
  endtask

  function automatic string tag_s(input int s);
    return (s == 0) ? "d4" : "d5";
  endfunction

  task automatic run_txn(input int s, input bit f, input logic [23:0] a, input logic [31:0] w,
                         input int exp_cyc, input int pulse_at, input string tag);
    int k;
    logic [71:0] m;
    logic [7:0]  op;
    op = f ? 8'h0B : 8'h03;
    start_req(s, f, a, w);
    chk({tag, "_csn_c1"}, csn[s], 0);
    chk({tag, "_busy_c1"}, busy[s], 1);
    chk({tag, "_di_c1"}, di[s], 0);
    k = 1;
    while (!done[s] && k < 2000) begin
      @(negedge fast_clk); k++;
      req[s] = (k == pulse_at);
    end
    req[s] = 1'b0;
    chk({tag, "_done_cycle"}, k, exp_cyc);
    chk({tag, "_data"}, (s == 0) ? data0 : data1, w);
    chk({tag, "_csn_up"}, csn[s], 1);
    chk({tag, "_rises"}, (s == 0) ? rise0 : rise1, f ? 72 : 64);
    m = (s == 0) ? mosi0 : mosi1;
    if (f) begin
      chk({tag, "_mosi_hdr"}, m[71:40], {op, a});
      chk({tag, "_mosi_dummy_data"}, m[39:0], 0);
    end else begin
      chk({tag, "_mosi_hdr"}, m[63:32], {op, a});
      chk({tag, "_mosi_data"}, m[31:0], 0);
    end
  endtask

  initial begin
    int j, k, dn, lowcnt;
    bit f;
    logic [23:0] a;
    logic [31:0] w;
    rst_n = 1'b0; req = '0; cmd = '0; addr0 = '0; addr1 = '0;
    repeat (3) @(negedge fast_clk);
    chk("rst_csn", csn, 2'b11);
    chk("rst_clk", qclk, 2'b00);
    chk("rst_di", di, 2'b00);
    chk("rst_busy", busy, 2'b00);
    chk("rst_done", done, 2'b00);
    chk("rst_data", data0, 0);
    chk("rst_wp_hold", {wpn, holdn}, 4'hF);
    rst_n = 1'b1;
    repeat (2) @(negedge fast_clk);

    run_txn(0, 1'b0, 24'h012340, 32'hA5C30F96, 521, -1, "rd03");
    run_txn(0, 1'b1, 24'hFFFFF0, 32'h12345678, 585, -1, "rd0b");

    // Pulse during SHIFT (cycle 100) and during GAP: both must be ignored.
    run_txn(0, 1'b0, 24'h000ABC, 32'hDEADBEEF, 521, 100, "busy_shift");
    j = 0;
    while (busy[0] && j < 100) begin
      @(negedge fast_clk); j++;
      req[0] = (j == 2);
    end
    req[0] = 1'b0;
    chk("gap_busy_fall", j, 8);
    lowcnt = 0;
    repeat (20) begin @(negedge fast_clk); if (!csn[0] || busy[0]) lowcnt++; end
    chk("gap_pulse_ignored", lowcnt, 0);

    // Held request right after rd_done is accepted as soon as busy drops.
    run_txn(0, 1'b1, 24'h55AA33, 32'hCAFEF00D, 585, -1, "held_a");
    addr0 = 24'h13579B; word0 = 32'h0BADF00D; cmd[0] = 1'b0; req[0] = 1'b1;
    j = 0;
    while (csn[0] && j < 100) begin @(negedge fast_clk); j++; end
    req[0] = 1'b0;
    chk("held_csn_gap", j, 9);
    k = 1;
    while (!done[0] && k < 2000) begin @(negedge fast_clk); k++; end
    chk("held_b_done_cycle", k, 521);
    chk("held_b_data", data0, 32'h0BADF00D);

    run_txn(1, 1'b0, 24'h0F0F0F, 32'h89ABCDEF, 651, -1, "div5");
    chk("div5_phase_bad", bad5, 0);
    chk("div5_phase_count", nphase5, 127);

    // Reset during address bit 20 (bit counter 28).
    start_req(0, 1'b0, 24'hABCDEF, 32'h11223344);
    k = 0;
    while (rise0 < 29 && k < 1000) begin @(negedge fast_clk); k++; end
    chk("mid_rise_reached", rise0, 29);
    dn = done_cnt0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_csn", csn[0], 1);
    chk("mid_rst_clk", qclk[0], 0);
    chk("mid_rst_busy", busy[0], 0);
    chk("mid_rst_data", data0, 0);
    chk("mid_rst_di", di[0], 0);
    repeat (5) @(negedge fast_clk);
    rst_n = 1'b1;
    repeat (3) @(negedge fast_clk);
    chk("mid_rst_no_done", done_cnt0, dn);
    run_txn(0, 1'b0, 24'h2468AC, 32'h5A5AC3C3, 521, -1, "post_rst");

    for (int i = 0; i < 10; i++) begin
      f = i[0];
      a = 24'($urandom);
      w = $urandom;
      run_txn(0, f, a, w, f ? 585 : 521, -1, "alt");
    end
    chk("wp_hold_const", wp_bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/qspi_rd_master.md
# qspi_rd_master

SPI-mode (single-bit) flash-read initiator clocked from `fast_clk`. It issues Read (03h) or Fast Read (0Bh) transactions: command, 24-bit address, an optional dummy byte, then one 32-bit data word. It drives the serial bus toward the QSPI flash-emulation slave and returns the captured word to the requesting logic. It is the host-side counterpart used to exercise and bring up the qspi2sdram read path.

## Interface

Parameters:
- `CLK_DIV`, default 4: `fast_clk` cycles per `qspi_clk` half-period. Legal range 4..255.
- `CSN_GAP`, default 8: minimum `fast_clk` cycles `qspi_csn` stays high between transactions. Legal range 1..255.

Ports:
- `fast_clk`, in, 1: single clock for the whole block, 80 MHz. No other clock is used.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `rd_req`, in, 1: request. Sampled only when `rd_busy`=0.
- `rd_cmd_fast`, in, 1: 1 selects 0Bh (with 8 dummy clocks); 0 selects 03h.
- `rd_addr`, in, 24: byte address, sent MSB first.
- `rd_busy`, out, 1: transaction in progress or in the CS gap.
- `rd_done`, out, 1: one-cycle pulse; `rd_data` is valid from this cycle on.
- `rd_data`, out, 32: captured word. The first received bit lands in bit 31. Held until the next `rd_done`.
- `qspi_clk`, out, 1: serial clock, idles low (mode 0).
- `qspi_csn`, out, 1: chip select, active low.
- `qspi_di`, out, 1: master-out line (the slave's data input).
- `qspi_do`, in, 1: master-in line (the slave's data output).
- `qspi_wpn`, out, 1: driven constant 1.
- `qspi_holdn`, out, 1: driven constant 1.

## Operation

- **Reset values:**
  - `qspi_csn`=1, `qspi_clk`=0, `qspi_di`=0, `qspi_wpn`=1, `qspi_holdn`=1.
  - `rd_busy`=0, `rd_done`=0, `rd_data`=0.
  - FSM in IDLE; all counters 0.
- **FSM states:** IDLE, SETUP, SHIFT, HOLD, GAP.
  - IDLE: when `rd_req`=1, latch the opcode (0Bh or 03h), `rd_addr` and `rd_cmd_fast` into a shift register, then go to SETUP.
  - SETUP: lasts CLK_DIV cycles. `qspi_csn`=0, `qspi_clk`=0, `qspi_di` = opcode bit 7. Then go to SHIFT.
  - SHIFT: runs N `qspi_clk` periods, each a low phase then a high phase of CLK_DIV cycles. N=64 for 03h, N=72 for 0Bh. Then go to HOLD.
  - HOLD: lasts CLK_DIV cycles with `qspi_clk`=0 and `qspi_csn`=0. Then set `qspi_csn`=1, pulse `rd_done`, and go to GAP.
  - GAP: lasts CSN_GAP cycles, then go to IDLE.
- **Bit counter:** 7 bits, counts `qspi_clk` periods 0..N-1.
  - Bits 0-7: opcode.
  - Bits 8-31: address.
  - Bits 32-39: dummy, only for 0Bh; `qspi_di`=0 during these bits.
  - Remaining 32 bits: data phase; `qspi_di`=0.
- **Launch:** `qspi_di` changes only on the cycle `qspi_clk` goes 1→0, or on SETUP entry. The slave samples on the rising edge.
- **Capture:** during data bits, `qspi_do` is shifted into the LSB of the capture register on the `fast_clk` cycle in which `qspi_clk` is driven 1→0. Sampling at the end of the high phase allows for the slave's launch delay after the rising edge.
- **rd_data update:** loaded from the capture register only on the `rd_done` cycle.
- **rd_busy:** high from the cycle after acceptance until the last GAP cycle inclusive. `rd_req` while `rd_busy`=1 is ignored and is not queued.
- **Reset mid-transaction:** all outputs return to their reset values immediately (asynchronous). No `rd_done` is issued. `rd_data` is cleared to 0.

## Timing

- D = CLK_DIV. Cycle 0 is the IDLE cycle in which `rd_req`=1 is accepted.
- Cycle 1: `qspi_csn` falls, `rd_busy` rises, `qspi_di` = opcode MSB.
- First `qspi_clk` rising edge: cycle 1+2D.
- 03h transaction:
  - `qspi_csn` rises and `rd_done` pulses at cycle 1+130D.
  - With D=4 this is cycle 521.
- 0Bh transaction:
  - `qspi_csn` rises and `rd_done` pulses at cycle 1+146D.
  - With D=4 this is cycle 585.
- `rd_busy` falls at cycle (`rd_done` cycle)+CSN_GAP.
- Earliest next acceptance is the same cycle `rd_busy` falls, since IDLE samples `rd_req`.
- `qspi_clk` duty is exactly 50% for both odd and even D.
- `qspi_clk` makes no glitches or partial periods at CS edges.

## Test plan

- **03h read:** D=4, `rd_addr`=0x012340; slave model returns bytes A5,C3,0F,96.
  - MOSI stream is 03 01 23 40.
  - Exactly 64 rising edges occur.
  - `rd_done` at cycle 521 with `rd_data`=0xA5C30F96.
- **0Bh read:** `rd_addr`=0xFFFFF0; slave returns 0x12345678.
  - 72 rising edges occur.
  - The 8 dummy bits on `qspi_di` are 0.
  - `rd_done` at cycle 585 with `rd_data`=0x12345678.
- **Request while busy:** pulse `rd_req` during SHIFT and again during GAP.
  - Neither starts a transaction.
  - After the gap, a held `rd_req` starts exactly CSN_GAP cycles after `rd_done`, and `qspi_csn` stays high for ≥CSN_GAP cycles.
- **Odd divider:** CLK_DIV=5.
  - Every `qspi_clk` high and low phase is exactly 5 cycles.
  - 03h `rd_done` at cycle 651.
- **Reset mid-transaction:** assert `rst_n`=0 at bit 20 of the address phase.
  - Same cycle: `qspi_csn`=1, `qspi_clk`=0, `rd_busy`=0, `rd_data`=0.
  - No `rd_done` pulse.
  - After release, a new 03h completes correctly.
- **Back-to-back alternating commands:** alternate 03h and 0Bh five times with random addresses and data.
  - Every word matches the slave model.
  - `qspi_wpn` and `qspi_holdn` stay 1 throughout.
